// File: rtl/level_scroller.sv
// level_scroller: scrolling ground stripe plus up to NOBS scrolling obstacles.
// Produces a registered colour index for the pixel mux, the lane of any
// obstacle crossing the player column, and the number of live obstacles.

// One obstacle slot: position and lane state, pixel hit and player-overlap tests.
module level_scroller_slot #(
    parameter int CORDW    = 10,
    parameter int X_MIN    = 170,
    parameter int X_MAX    = 750,
    parameter int GROUND_Y = 308,
    parameter int SPEED    = 2,
    parameter int OBS_W    = 16,
    parameter int OBS_H    = 20,
    parameter int PLAYER_X = 200,
    parameter int PLAYER_W = 24
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             step,
    input  logic             spawn,
    input  logic [1:0]       spawn_lane,
    input  logic [CORDW-1:0] hc,
    input  logic [CORDW-1:0] vc,
    output logic             valid,
    output logic [1:0]       lane,
    output logic             hit,
    output logic             danger
);
    logic [CORDW-1:0] x;

    // Slot state: spawn at the right edge, scroll left, retire before crossing X_MIN.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid <= 1'b0;
            x     <= '0;
            lane  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (spawn) begin
            valid <= 1'b1;
            x     <= CORDW'(X_MAX);
            lane  <= spawn_lane;
        end else if (step && valid) begin
            if (x < CORDW'(X_MIN + SPEED))
                valid <= 1'b0;
            else
                x <= x - CORDW'(SPEED);
        end
    end

    // Box tests done in int so x+OBS_W and the lane band never wrap.
    always_comb begin
        int xi, hi, vi, top;
        xi  = int'(x);
        hi  = int'(hc);
        vi  = int'(vc);
        top = GROUND_Y - int'(lane) * OBS_H;
        hit    = valid && (hi >= xi) && (hi < xi + OBS_W) &&
                 (vi >= top) && (vi < top + OBS_H);
        danger = valid && (xi < PLAYER_X + PLAYER_W) && (xi + OBS_W > PLAYER_X);
    end
endmodule

module level_scroller #(
    parameter int CIDXW     = 3,
    parameter int CORDW     = 10,
    parameter int NOBS      = 4,
    parameter int X_MIN     = 170,
    parameter int X_MAX     = 750,
    parameter int GROUND_Y  = 308,
    parameter int SPEED     = 2,
    parameter int COOLDOWN  = 40,
    parameter int OBS_W     = 16,
    parameter int OBS_H     = 20,
    parameter int PLAYER_X  = 200,
    parameter int PLAYER_W  = 24,
    parameter int GND_COLOR = 7,
    parameter int OBS_COLOR = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             run,
    input  logic             clear,
    input  logic             frame_tick,
    input  logic [CORDW-1:0] hc,
    input  logic [CORDW-1:0] vc,
    output logic [CIDXW:0]   level_pix,
    output logic [1:0]       danger_lane,
    output logic [3:0]       obs_count
);
    localparam int CDW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    logic [2:0]            phase;
    logic [7:0]            lfsr;
    logic [CDW-1:0]        cooldown;
    logic                  step, attempt, any_free;
    logic [NOBS-1:0]       slot_valid, slot_hit, slot_danger, spawn_sel;
    logic [NOBS-1:0][1:0]  slot_lane;
    logic [CIDXW:0]        pix_next;
    logic [1:0]            danger_next;
    logic [3:0]            count_next;

    // clear wins over frame_tick; nothing moves while the game is not running.
    assign step    = frame_tick && run && !clear;
    assign attempt = step && (cooldown == '0) && (lfsr[1:0] != 2'd0);

    generate
        for (genvar i = 0; i < NOBS; i++) begin : g_slot
            level_scroller_slot #(
                .CORDW(CORDW), .X_MIN(X_MIN), .X_MAX(X_MAX), .GROUND_Y(GROUND_Y),
                .SPEED(SPEED), .OBS_W(OBS_W), .OBS_H(OBS_H),
                .PLAYER_X(PLAYER_X), .PLAYER_W(PLAYER_W)
            ) u_slot (
                .Clk(Clk), .Reset(Reset), .clear(clear), .step(step),
                .spawn(spawn_sel[i]), .spawn_lane(lfsr[1:0]),
                .hc(hc), .vc(vc),
                .valid(slot_valid[i]), .lane(slot_lane[i]),
                .hit(slot_hit[i]), .danger(slot_danger[i])
            );
        end
    endgenerate

    // Pick the lowest slot that is free before this frame's scroll.
    always_comb begin
        spawn_sel = '0;
        any_free  = 1'b0;
        for (int i = 0; i < NOBS; i++) begin
            if (!slot_valid[i] && !any_free) begin
                spawn_sel[i] = attempt;
                any_free     = 1'b1;
            end
        end
    end

    // Per-frame scroll phase, LFSR step and spawn cooldown.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase    <= '0;
            lfsr     <= 8'hA5;
            cooldown <= CDW'(COOLDOWN);
        end else if (clear) begin
            phase    <= '0;
            cooldown <= CDW'(COOLDOWN);
        end else if (step) begin
            phase <= phase - 3'(SPEED);
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (cooldown != '0)
                cooldown <= cooldown - 1'b1;
            else if (lfsr[1:0] == 2'd0 || any_free)
                cooldown <= CDW'(COOLDOWN);
            // else: all slots busy, stay at 0 and retry next frame
        end
    end

    // Pixel colour: obstacles over the two-row dashed ground stripe.
    always_comb begin
        pix_next = '0;
        if (run && hc >= CORDW'(X_MIN) && hc <= CORDW'(X_MAX)) begin
            if (|slot_hit)
                pix_next = (CIDXW+1)'(OBS_COLOR);
            else if (vc == CORDW'(GROUND_Y) && hc[2:0] == phase)
                pix_next = (CIDXW+1)'(GND_COLOR);
            else if (vc == CORDW'(GROUND_Y + 1) && hc[2:0] != phase)
                pix_next = (CIDXW+1)'(GND_COLOR);
        end
    end

    // Lane of the lowest overlapping slot, and live slot count.
    always_comb begin
        logic found;
        danger_next = '0;
        count_next  = '0;
        found       = 1'b0;
        for (int i = 0; i < NOBS; i++) begin
            count_next = count_next + 4'(slot_valid[i]);
            if (slot_danger[i] && !found) begin
                danger_next = slot_lane[i];
                found       = 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            level_pix   <= '0;
            danger_lane <= '0;
            obs_count   <= '0;
        end else if (clear) begin
            level_pix   <= '0;
            danger_lane <= '0;
            obs_count   <= '0;
        end else begin
            level_pix   <= pix_next;
            danger_lane <= run ? danger_next : 2'd0;
            obs_count   <= count_next;
        end
    end
endmodule
